// File: rtl/envelope_follower_pkg.sv
// envelope_follower_pkg
//   Shared types and helpers for the envelope follower:
//     gate_state_t  - gate FSM state encoding (CLOSED, OPEN, HOLD)
//     sat_abs()     - saturating absolute value of a w-bit two's-complement
//                     sample (passed sign-extended to 32 bits)
//     DEFAULT_*     - default gate thresholds and hold length
package envelope_follower_pkg;

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        OPEN   = 2'd1,
        HOLD   = 2'd2
    } gate_state_t;

    localparam logic [15:0] DEFAULT_THRESH_ON    = 16'h1000;
    localparam logic [15:0] DEFAULT_THRESH_OFF   = 16'h0800;
    localparam int          DEFAULT_HOLD_SAMPLES = 64;

    // |x| for a w-bit signed value held sign-extended in x.
    // The most negative value -2^(w-1) saturates to 2^(w-1)-1, so the
    // result always fits in w-1 magnitude bits.
    function automatic logic [31:0] sat_abs(input logic [31:0] x, input int unsigned w);
        logic [31:0] mag;
        logic [31:0] lim;
        lim = (32'd1 << (w - 32'd1)) - 32'd1;
        if (x[31]) begin
            mag = ~x + 32'd1;
        end else begin
            mag = x;
        end
        if (mag > lim) begin
            mag = lim;
        end else begin
            mag = mag;
        end
        return mag;
    endfunction

endpackage

// File: rtl/envelope_follower_gate_fsm.sv
// env_gate_fsm
//   Hysteretic gate derived from the smoothed envelope. The state only moves
//   on env_valid cycles; gate_out and trigger_out are registered, so they
//   change the cycle after the env_valid that caused the transition.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   env_in       - registered envelope value (unsigned, W bits)
//   env_valid    - qualifies env_in for one cycle
//   gate_out     - high while OPEN or HOLD
//   trigger_out  - one-cycle pulse on each CLOSED -> OPEN transition
module env_gate_fsm
    import envelope_follower_pkg::*;
#(
    parameter int             W            = 16,
    parameter logic [W-1:0]   THRESH_ON    = DEFAULT_THRESH_ON,
    parameter logic [W-1:0]   THRESH_OFF   = DEFAULT_THRESH_OFF,
    parameter int             HOLD_SAMPLES = DEFAULT_HOLD_SAMPLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] env_in,
    input  logic         env_valid,
    output logic         gate_out,
    output logic         trigger_out
);

    // HOLD_SAMPLES of 0 behaves like 1: the counter is loaded with 0 and
    // HOLD ends on the very next env_valid.
    localparam int HOLD_LOAD = (HOLD_SAMPLES > 0) ? (HOLD_SAMPLES - 1) : 0;
    localparam int HOLD_W    = (HOLD_SAMPLES > 2) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD_V = HOLD_LOAD[HOLD_W-1:0];
    localparam logic [HOLD_W-1:0] CNT_ONE     = HOLD_W'(1);

    gate_state_t       state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              gate_q, gate_d;
    logic              trig_q, trig_d;

    // Next-state, hold counter and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        if (env_valid) begin
            case (state_q)
                CLOSED: begin
                    if (env_in >= THRESH_ON) begin
                        state_d = OPEN;
                        trig_d  = 1'b1;
                    end else begin
                        state_d = CLOSED;
                    end
                end
                OPEN: begin
                    if (env_in < THRESH_OFF) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD_V;
                    end else begin
                        state_d = OPEN;
                    end
                end
                HOLD: begin
                    // A re-crossing of THRESH_ON during hold reopens silently.
                    if (env_in >= THRESH_ON) begin
                        state_d = OPEN;
                    end else if (cnt_q == {HOLD_W{1'b0}}) begin
                        state_d = CLOSED;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = CLOSED;
                    cnt_d   = {HOLD_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
        gate_d = (state_d != CLOSED);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLOSED;
            cnt_q   <= {HOLD_W{1'b0}};
            gate_q  <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate_d;
            trig_q  <= trig_d;
        end
    end

    assign gate_out    = gate_q;
    assign trigger_out = trig_q;

endmodule

// File: rtl/envelope_follower.sv
// envelope_follower
//   Audio-rate envelope detector: rectifies a signed sample stream, smooths
//   it with separate attack/release shifts and drives a hysteretic gate.
//   Pipeline: sample_valid -> rect (1 cycle) -> env (1 cycle) -> gate (1 cycle).
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   sample_valid  - one-cycle strobe qualifying sample_in (back-to-back ok)
//   sample_in     - signed W-bit sample
//   env_out       - unsigned envelope, 0 .. 2^(W-1)-1
//   env_valid     - one-cycle pulse when env_out takes a new value
//   gate_out      - gate open (OPEN or HOLD)
//   trigger_out   - one-cycle pulse on gate opening
//   peak_clear / peak_out - only with ENVELOPE_FOLLOWER_PEAK_EN defined:
//                   running maximum of env_out, restartable by peak_clear
module envelope_follower
    import envelope_follower_pkg::*;
#(
    parameter int           W             = 16,
    parameter int           ATTACK_SHIFT  = 2,
    parameter int           RELEASE_SHIFT = 8,
    parameter logic [W-1:0] THRESH_ON     = DEFAULT_THRESH_ON,
    parameter logic [W-1:0] THRESH_OFF    = DEFAULT_THRESH_OFF,
    parameter int           HOLD_SAMPLES  = DEFAULT_HOLD_SAMPLES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_valid,
    input  logic [W-1:0] sample_in,
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
    input  logic         peak_clear,
    output logic [W-1:0] peak_out,
`endif
    output logic [W-1:0] env_out,
    output logic         env_valid,
    output logic         gate_out,
    output logic         trigger_out
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] rect_q, rect_d;
    logic         rect_vld_q, rect_vld_d;
    logic [W-1:0] env_q, env_d;
    logic         env_vld_q, env_vld_d;
    logic [W-1:0] diff_s;
    logic [W-1:0] up_step_s;
    logic [W-1:0] dn_step_s;

    // Stage 1: saturating rectifier.
    always_comb begin
        rect_vld_d = sample_valid;
        if (sample_valid) begin
            rect_d = W'(sat_abs(32'(signed'(sample_in)), W));
        end else begin
            rect_d = rect_q;
        end
    end

    // Stage 2: one-pole smoothing with a minimum step of 1 so env always
    // converges onto rect. The step never exceeds diff, so env stays
    // between its old value and rect and cannot wrap.
    always_comb begin
        env_vld_d = rect_vld_q;
        if (rect_q > env_q) begin
            diff_s = rect_q - env_q;
        end else begin
            diff_s = env_q - rect_q;
        end
        up_step_s = diff_s >> ATTACK_SHIFT;
        if (up_step_s == {W{1'b0}}) begin
            up_step_s = ONE;
        end else begin
            up_step_s = up_step_s;
        end
        dn_step_s = diff_s >> RELEASE_SHIFT;
        if (dn_step_s == {W{1'b0}}) begin
            dn_step_s = ONE;
        end else begin
            dn_step_s = dn_step_s;
        end
        env_d = env_q;
        if (rect_vld_q) begin
            if (rect_q > env_q) begin
                env_d = env_q + up_step_s;
            end else if (rect_q < env_q) begin
                env_d = env_q - dn_step_s;
            end else begin
                env_d = env_q;
            end
        end else begin
            env_d = env_q;
        end
    end

    // Pipeline registers for rectifier and envelope.
    always_ff @(posedge clk) begin
        if (reset) begin
            rect_q     <= {W{1'b0}};
            rect_vld_q <= 1'b0;
            env_q      <= {W{1'b0}};
            env_vld_q  <= 1'b0;
        end else begin
            rect_q     <= rect_d;
            rect_vld_q <= rect_vld_d;
            env_q      <= env_d;
            env_vld_q  <= env_vld_d;
        end
    end

    assign env_out   = env_q;
    assign env_valid = env_vld_q;

    env_gate_fsm #(
        .W            (W),
        .THRESH_ON    (THRESH_ON),
        .THRESH_OFF   (THRESH_OFF),
        .HOLD_SAMPLES (HOLD_SAMPLES)
    ) u_gate (
        .clk         (clk),
        .reset       (reset),
        .env_in      (env_q),
        .env_valid   (env_vld_q),
        .gate_out    (gate_out),
        .trigger_out (trigger_out)
    );

`ifdef ENVELOPE_FOLLOWER_PEAK_EN
    logic [W-1:0] peak_q, peak_d;

    // Peak tracker: a clear without a fresh envelope restarts from 0,
    // a clear coinciding with env_valid restarts from that envelope.
    always_comb begin
        peak_d = peak_q;
        if (env_vld_q) begin
            if (peak_clear) begin
                peak_d = env_q;
            end else if (env_q > peak_q) begin
                peak_d = env_q;
            end else begin
                peak_d = peak_q;
            end
        end else if (peak_clear) begin
            peak_d = {W{1'b0}};
        end else begin
            peak_d = peak_q;
        end
    end

    // Peak register.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= {W{1'b0}};
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_out = peak_q;
`endif

endmodule

// File: tb/tb_envelope_follower.sv
// tb_envelope_follower
//   Directed bench for envelope_follower with default parameters
//   (ATTACK_SHIFT=2, RELEASE_SHIFT=8, ON=0x1000, OFF=0x0800, HOLD=64).
module tb_envelope_follower;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic [15:0] env_out;
    logic        env_valid;
    logic        gate_out;
    logic        trigger_out;
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
    logic        peak_clear = 1'b0;
    logic [15:0] peak_out;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    envelope_follower dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
        .peak_clear   (peak_clear),
        .peak_out     (peak_out),
`endif
        .env_out      (env_out),
        .env_valid    (env_valid),
        .gate_out     (gate_out),
        .trigger_out  (trigger_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sample;
        logic [15:0] exp_env;
        logic        exp_gate;
        logic        exp_trig;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 16'h0000;
        step();
        step();
        reset = 1'b0;
    endtask

    // One isolated sample; check env two edges later and gate one edge after.
    task automatic send_vec(input vec_t v, input int idx);
        sample_valid = 1'b1;
        sample_in    = v.sample;
        step();
        sample_valid = 1'b0;
        chk($sformatf("v%0d_no_early_valid", idx), {31'd0, env_valid}, 32'd0);
        step();
        chk($sformatf("v%0d_env_valid", idx), {31'd0, env_valid}, 32'd1);
        chk($sformatf("v%0d_env", idx), {16'd0, env_out}, {16'd0, v.exp_env});
        step();
        chk($sformatf("v%0d_gate", idx), {31'd0, gate_out}, {31'd0, v.exp_gate});
        chk($sformatf("v%0d_trig", idx), {31'd0, trigger_out}, {31'd0, v.exp_trig});
        chk($sformatf("v%0d_valid_pulse", idx), {31'd0, env_valid}, 32'd0);
    endtask

    task automatic stream(input logic [15:0] s);
        sample_valid = 1'b1;
        sample_in    = s;
        step();
    endtask

    // Open the gate, decay with zeros into HOLD, then either let hold expire
    // or (retrig) push the envelope back above THRESH_ON after 30 hold pulses.
    task automatic hold_run(input bit retrig);
        int  k        = -1;
        int  drop_k   = -1;
        int  trigs    = 0;
        int  gate_low = 0;
        int  extra    = -1;
        bit  prev_ev  = 1'b0;
        bit  done     = 1'b0;
        apply_reset();
        for (int i = 0; i < 20; i++) stream(16'h7FFF);
        chk(retrig ? "rt_gate_open" : "hold_gate_open", {31'd0, gate_out}, 32'd1);
        for (int c = 0; c < 4000 && !done; c++) begin
            stream((retrig && k >= 30) ? 16'h7FFF : 16'h0000);
            if (k >= 0 && prev_ev) begin
                if (!gate_out && drop_k < 0) drop_k = k;
                if (!gate_out) gate_low++;
                if (trigger_out) trigs++;
            end
            if (env_valid && k < 0 && env_out < 16'h0800) begin
                k = 0;
            end else if (env_valid && k >= 0) begin
                k++;
            end
            prev_ev = env_valid;
            if (!retrig && drop_k >= 0) done = 1'b1;
            if (retrig && k >= 30 && env_out >= 16'h1000 && extra < 0) extra = 4;
            if (extra > 0) extra--;
            if (extra == 0) done = 1'b1;
        end
        sample_valid = 1'b0;
        chk(retrig ? "rt_finished" : "hold_finished", {31'd0, done}, 32'd1);
        if (!retrig) begin
            chk("hold_drop_after_pulses", drop_k, 32'd64);
            chk("hold_no_trigger", trigs, 32'd0);
        end else begin
            chk("rt_gate_never_low", gate_low, 32'd0);
            chk("rt_no_trigger", trigs, 32'd0);
            chk("rt_gate_still_open", {31'd0, gate_out}, 32'd1);
        end
    endtask

    initial begin
        vecs[0] = '{16'h4000, 16'h1000, 1'b1, 1'b1};
        vecs[1] = '{16'h4000, 16'h1C00, 1'b1, 1'b0};
        vecs[2] = '{16'h4000, 16'h2500, 1'b1, 1'b0};
        vecs[3] = '{16'h4000, 16'h2BC0, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 16'h2B95, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h40AF, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h406F, 1'b1, 1'b0};
        vecs[7] = '{16'h406F, 16'h406F, 1'b1, 1'b0};
        vecs[8] = '{16'hBF91, 16'h406F, 1'b1, 1'b0};

        // Reset held with sample_valid toggling: outputs stay 0.
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            sample_valid = ~sample_valid;
            step();
            chk($sformatf("reset_outs_%0d", i),
                {13'd0, env_valid, gate_out, trigger_out, env_out}, 32'd0);
        end
        reset        = 1'b0;
        sample_valid = 1'b0;
        step();
        chk("post_reset_no_stale_valid", {31'd0, env_valid}, 32'd0);
        step();
        chk("post_reset_no_stale_valid2", {31'd0, env_valid}, 32'd0);

        // Table of isolated samples (attack, release, saturation, abs).
        for (int i = 0; i < 9; i++) send_vec(vecs[i], i);

        // Saturation from zero with -32768.
        apply_reset();
        send_vec('{16'h8000, 16'h1FFF, 1'b1, 1'b1}, 100);

        // -1 from zero: env climbs to exactly 1 and stays.
        apply_reset();
        for (int i = 0; i < 10; i++) stream(16'hFFFF);
        sample_valid = 1'b0;
        step();
        chk("neg1_env", {16'd0, env_out}, 32'd1);
        chk("neg1_gate", {31'd0, gate_out}, 32'd0);

        // Convergence on constant 0x4000 every cycle.
        begin
            logic [15:0] first [3];
            int n_ev = 0, overs = 0, trigs = 0, devs = 0;
            bit reached = 1'b0;
            apply_reset();
            for (int i = 0; i < 80; i++) begin
                stream(16'h4000);
                trigs += trigger_out;
                if (env_valid) begin
                    if (n_ev < 3) first[n_ev] = env_out;
                    n_ev++;
                    if (env_out > 16'h4000) overs++;
                    if (reached && env_out != 16'h4000) devs++;
                    if (env_out == 16'h4000) reached = 1'b1;
                end
            end
            sample_valid = 1'b0;
            step();
            trigs += trigger_out;
            step();
            trigs += trigger_out;
            chk("conv_0", {16'd0, first[0]}, 32'h1000);
            chk("conv_1", {16'd0, first[1]}, 32'h1C00);
            chk("conv_2", {16'd0, first[2]}, 32'h2500);
            chk("conv_final", {16'd0, env_out}, 32'h4000);
            chk("conv_overshoot", overs, 32'd0);
            chk("conv_stays", devs, 32'd0);
            chk("conv_one_trigger", trigs, 32'd1);
        end

        hold_run(1'b0);
        hold_run(1'b1);

        // Reset mid-attack with both stages valid and gate open.
        apply_reset();
        for (int i = 0; i < 5; i++) stream(16'h4000);
        chk("mid_pre_gate", {31'd0, gate_out}, 32'd1);
        reset = 1'b1;
        step();
        chk("mid_reset_outs", {13'd0, env_valid, gate_out, trigger_out, env_out}, 32'd0);
        reset        = 1'b0;
        sample_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mid_no_stale_%0d", i),
                {13'd0, env_valid, gate_out, trigger_out, env_out}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
